// File: rtl/sync_fifo_ext.sv
// Parametrised synchronous FIFO: any depth, standard or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_ext #(
    parameter int unsigned DATA_LEN   = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_LEN-1:0]   data_in,
    input  logic                  rd_en,
    output logic [DATA_LEN-1:0]   data_out,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned LastIdx = DEPTH - 1;
    localparam logic [ADDR_WIDTH-1:0] LastPtr  = LastIdx[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   DepthCnt = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AfCnt    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AeCnt    = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_LEN-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, full_q, af_q, ae_q;
    logic                  overflow_q, underflow_q;
    logic [DATA_LEN-1:0]   dout_q;
    logic                  rd_valid_q;
    logic                  rd_acc, wr_acc;

    // A write at full still goes in when a read frees a slot on the same edge.
    assign rd_acc = rd_en & ~empty_q;
    assign wr_acc = wr_en & (~full_q | rd_acc);

    // Explicit wrap compare so non-power-of-2 depths stay inside the array.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        end
        count_d = count_q + (ADDR_WIDTH + 1)'(wr_acc) - (ADDR_WIDTH + 1)'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (!sys_rst && !flush && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            dout_q      <= '0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == DepthCnt);
            af_q        <= (count_d >= AfCnt);
            ae_q        <= (count_d <= AeCnt);
            overflow_q  <= overflow_q | (wr_en & ~wr_acc);
            underflow_q <= underflow_q | (rd_en & ~rd_acc);
            rd_valid_q  <= rd_acc;
            if (rd_acc) begin
                dout_q <= mem[rd_ptr_q];
            end
        end
    end

    assign data_out     = (FWFT != 0) ? mem[rd_ptr_q] : dout_q;
    assign rd_valid     = (FWFT != 0) ? ~empty_q : rd_valid_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: a DEPTH=5 standard-read instance and a DEPTH=5 FWFT instance.
module tb_sync_fifo_ext;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode instance signals
    logic       s_rst = 1'b0, s_flush = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
    logic [7:0] s_din = '0, s_dout;
    logic       s_rv, s_empty, s_full, s_af, s_ae, s_of, s_uf;
    logic [3:0] s_cnt;

    // FWFT instance signals
    logic       f_rst = 1'b0, f_flush = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_din = '0, f_dout;
    logic       f_rv, f_empty, f_full, f_af, f_ae, f_of, f_uf;
    logic [3:0] f_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_ext #(
        .DATA_LEN(8), .DEPTH(5), .ADDR_WIDTH(3), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)
    ) u_std (
        .clk(clk), .sys_rst(s_rst), .flush(s_flush), .wr_en(s_wr), .data_in(s_din),
        .rd_en(s_rd), .data_out(s_dout), .rd_valid(s_rv), .empty(s_empty), .full(s_full),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt), .overflow(s_of),
        .underflow(s_uf)
    );

    sync_fifo_ext #(
        .DATA_LEN(8), .DEPTH(5), .ADDR_WIDTH(3), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)
    ) u_fwft (
        .clk(clk), .sys_rst(f_rst), .flush(f_flush), .wr_en(f_wr), .data_in(f_din),
        .rd_en(f_rd), .data_out(f_dout), .rd_valid(f_rv), .empty(f_empty), .full(f_full),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt), .overflow(f_of),
        .underflow(f_uf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs set before the call are sampled at the next rising edge; outputs checked 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_std_reset(input string tag);
        chk({tag, "_cnt"}, 32'(s_cnt), 0);
        chk({tag, "_empty"}, 32'(s_empty), 1);
        chk({tag, "_full"}, 32'(s_full), 0);
        chk({tag, "_ae"}, 32'(s_ae), 1);
        chk({tag, "_af"}, 32'(s_af), 0);
        chk({tag, "_of"}, 32'(s_of), 0);
        chk({tag, "_uf"}, 32'(s_uf), 0);
        chk({tag, "_rv"}, 32'(s_rv), 0);
        chk({tag, "_dout"}, 32'(s_dout), 0);
    endtask

    initial begin
        // Reset both instances
        s_rst = 1'b1; f_rst = 1'b1;
        step();
        s_rst = 1'b0; f_rst = 1'b0;
        chk_std_reset("rst");
        chk("f_rst_empty", 32'(f_empty), 1);
        chk("f_rst_rv", 32'(f_rv), 0);

        // Fill 1..5, flags track count
        for (int i = 1; i <= 5; i++) begin
            s_wr = 1'b1; s_din = 8'(i);
            step();
            chk("fill_cnt", 32'(s_cnt), 32'(i));
            chk("fill_af", 32'(s_af), 32'(i >= 4));
            chk("fill_ae", 32'(s_ae), 32'(i <= 1));
            chk("fill_full", 32'(s_full), 32'(i == 5));
            chk("fill_empty", 32'(s_empty), 0);
        end
        // Sixth write rejected
        s_din = 8'h06;
        step();
        s_wr = 1'b0;
        chk("ovf_cnt", 32'(s_cnt), 5);
        chk("ovf_flag", 32'(s_of), 1);
        chk("ovf_full", 32'(s_full), 1);

        // Drain: data one cycle after rd_en
        for (int i = 1; i <= 5; i++) begin
            s_rd = 1'b1;
            step();
            chk("drain_dout", 32'(s_dout), 32'(i));
            chk("drain_rv", 32'(s_rv), 1);
            chk("drain_cnt", 32'(s_cnt), 32'(5 - i));
        end
        s_rd = 1'b0;
        chk("drain_empty", 32'(s_empty), 1);
        step();
        chk("idle_rv", 32'(s_rv), 0);
        chk("idle_dout_hold", 32'(s_dout), 5);
        chk("idle_uf", 32'(s_uf), 0);

        // Wrap: write 3, read 3, then 5 words across the DEPTH-1 -> 0 boundary
        for (int i = 0; i < 3; i++) begin
            s_wr = 1'b1; s_din = 8'(8'h11 + i);
            step();
        end
        s_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_rd = 1'b1;
            step();
            chk("pre_wrap_dout", 32'(s_dout), 32'(8'h11 + i));
        end
        s_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_wr = 1'b1; s_din = 8'(8'hA1 + i);
            step();
        end
        s_wr = 1'b0;
        chk("wrap_full", 32'(s_full), 1);
        for (int i = 0; i < 5; i++) begin
            s_rd = 1'b1;
            step();
            chk("wrap_dout", 32'(s_dout), 32'(8'hA1 + i));
        end
        s_rd = 1'b0;
        chk("wrap_empty", 32'(s_empty), 1);

        // Flush clears sticky overflow
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        chk("flush0_of", 32'(s_of), 0);

        // Full with simultaneous read and write
        for (int i = 0; i < 5; i++) begin
            s_wr = 1'b1; s_din = 8'(8'hB1 + i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            s_wr = 1'b1; s_rd = 1'b1; s_din = 8'(8'hC1 + i);
            step();
            chk("rw_full_cnt", 32'(s_cnt), 5);
            chk("rw_full_full", 32'(s_full), 1);
            chk("rw_full_dout", 32'(s_dout), 32'(8'hB1 + i));
        end
        s_wr = 1'b0;
        chk("rw_full_of", 32'(s_of), 0);
        begin
            logic [7:0] exp_q [5] = '{8'hB4, 8'hB5, 8'hC1, 8'hC2, 8'hC3};
            for (int i = 0; i < 5; i++) begin
                s_rd = 1'b1;
                step();
                chk("rw_drain_dout", 32'(s_dout), 32'(exp_q[i]));
            end
        end
        // Empty with both requests: write wins, read rejected
        s_wr = 1'b1; s_rd = 1'b1; s_din = 8'hD1;
        step();
        s_wr = 1'b0; s_rd = 1'b0;
        chk("rw_empty_cnt", 32'(s_cnt), 1);
        chk("rw_empty_uf", 32'(s_uf), 1);
        chk("rw_empty_rv", 32'(s_rv), 0);
        chk("rw_empty_dout", 32'(s_dout), 32'(8'hC3));

        // Build count=3 with overflow set, then flush with a concurrent write
        for (int i = 0; i < 5; i++) begin
            s_wr = 1'b1; s_din = 8'(8'hE2 + i);
            step();
        end
        s_wr = 1'b0;
        chk("pre_flush_of", 32'(s_of), 1);
        s_rd = 1'b1;
        step();
        chk("pre_flush_d1", 32'(s_dout), 32'(8'hD1));
        step();
        s_rd = 1'b0;
        chk("pre_flush_cnt", 32'(s_cnt), 3);
        s_flush = 1'b1; s_wr = 1'b1; s_din = 8'hFF;
        step();
        s_flush = 1'b0; s_wr = 1'b0;
        chk("flush_cnt", 32'(s_cnt), 0);
        chk("flush_empty", 32'(s_empty), 1);
        chk("flush_of", 32'(s_of), 0);
        chk("flush_uf", 32'(s_uf), 0);
        chk("flush_rv", 32'(s_rv), 0);
        chk("flush_dout_hold", 32'(s_dout), 32'(8'hE2));
        s_wr = 1'b1; s_din = 8'h77;
        step();
        s_wr = 1'b0; s_rd = 1'b1;
        step();
        s_rd = 1'b0;
        chk("post_flush_dout", 32'(s_dout), 32'(8'h77));
        chk("post_flush_cnt", 32'(s_cnt), 0);

        // Reset at count=4 with every other control asserted
        for (int i = 0; i < 4; i++) begin
            s_wr = 1'b1; s_din = 8'(8'h41 + i);
            step();
        end
        chk("pre_rst_cnt", 32'(s_cnt), 4);
        s_rst = 1'b1; s_flush = 1'b1; s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h99;
        step();
        s_rst = 1'b0; s_flush = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
        chk_std_reset("midrst");
        s_wr = 1'b1; s_din = 8'h55;
        step();
        s_wr = 1'b0;
        chk("post_rst_cnt", 32'(s_cnt), 1);
        s_rd = 1'b1;
        step();
        s_rd = 1'b0;
        chk("post_rst_dout", 32'(s_dout), 32'(8'h55));
        chk("post_rst_empty", 32'(s_empty), 1);

        // FWFT: head visible right after the write edge
        f_wr = 1'b1; f_din = 8'h3C;
        step();
        f_wr = 1'b0;
        chk("f_dout", 32'(f_dout), 32'(8'h3C));
        chk("f_rv", 32'(f_rv), 1);
        chk("f_cnt", 32'(f_cnt), 1);
        step();
        chk("f_hold_dout", 32'(f_dout), 32'(8'h3C));
        f_rd = 1'b1;
        step();
        f_rd = 1'b0;
        chk("f_pop_empty", 32'(f_empty), 1);
        chk("f_pop_rv", 32'(f_rv), 0);
        f_wr = 1'b1; f_din = 8'h5A;
        step();
        f_din = 8'h6B;
        step();
        f_wr = 1'b0;
        chk("f_head2", 32'(f_dout), 32'(8'h5A));
        f_rd = 1'b1;
        step();
        f_rd = 1'b0;
        chk("f_next", 32'(f_dout), 32'(8'h6B));
        chk("f_next_cnt", 32'(f_cnt), 1);
        chk("f_uf", 32'(f_uf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
